// File: rtl/data_sync_launch_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_launch_if
// Description : Bundle of the source-side handshake and the CDC launch bus.
//               slave  - the launcher (data_sync_launch)
//               master - the environment (word source + far-end acknowledge)
//   In_data   : word to transfer
//   In_valid  : In_data valid
//   In_ready  : launcher can accept a word
//   Async_bus : quasi-static data toward the destination domain
//   bus_EN    : enable (level pulse or toggle) toward the destination
//   Ack_async : toggle acknowledge from the destination domain
//   Busy      : inverse of In_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sync_launch_if #(
  parameter int Width = 8
);
  logic [Width-1:0] In_data;
  logic             In_valid;
  logic             In_ready;
  logic [Width-1:0] Async_bus;
  logic             bus_EN;
  logic             Ack_async;
  logic             Busy;

  modport master (
    output In_data, In_valid, Ack_async,
    input  In_ready, Async_bus, bus_EN, Busy
  );

  modport slave (
    input  In_data, In_valid, Ack_async,
    output In_ready, Async_bus, bus_EN, Busy
  );
endinterface
`default_nettype wire

// File: rtl/data_sync_launch.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_launch
// Description : Source-domain launcher for the enable-based CDC data path.
//               Accepts a word on valid/ready, parks it on Async_bus, then
//               signals the destination through bus_EN (a HOLD_CYCLES-long
//               pulse when S_TO_F=1, a toggle per word when S_TO_F=0). The
//               bus stays frozen until the destination's toggle acknowledge
//               has been synchronized back into CLK.
// Ports       : CLK    - source clock, rising edge
//               Reset  - asynchronous, active-high
//               bus    - data_sync_launch_if.slave (handshake + launch bus)
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_launch #(
  parameter int Width       = 8,
  parameter int NUM_Stages  = 2,
  parameter int S_TO_F      = 1,
  parameter int HOLD_CYCLES = 4
) (
  input wire logic              CLK,
  input wire logic              Reset,
  data_sync_launch_if.slave     bus
);

  localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [Width-1:0]       r_bus,    w_bus_nxt;
  logic                   r_en,     w_en_nxt;
  logic [c_CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic                   r_pend,   w_pend_nxt;
  logic [NUM_Stages-1:0]  r_ack_sync;
  logic                   r_ack_prev;
  logic                   w_ack_seen;

  // One-cycle pulse for every edge of the synchronized acknowledge toggle.
  assign w_ack_seen = r_ack_sync[NUM_Stages-1] ^ r_ack_prev;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_bus      <= '0;
      r_en       <= 1'b0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_ack_sync <= '0;
      r_ack_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bus      <= w_bus_nxt;
      r_en       <= w_en_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_ack_sync <= {r_ack_sync[NUM_Stages-2:0], bus.Ack_async};
      r_ack_prev <= r_ack_sync[NUM_Stages-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus_nxt   = r_bus;
    w_en_nxt    = r_en;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        // An ack arriving here is a far-end protocol error and is dropped.
        if (bus.In_valid) begin
          w_bus_nxt   = bus.In_data;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Data has been stable for a full cycle before the enable moves.
        if (w_ack_seen) w_pend_nxt = 1'b1;
        if (S_TO_F != 0) begin
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = c_CNT_W'(HOLD_CYCLES - 1);
          w_state_nxt = ST_HOLD;
        end else begin
          w_en_nxt    = ~r_en;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_HOLD: begin
        // Remember an early ack so WAIT_ACK does not stall for it.
        if (w_ack_seen) w_pend_nxt = 1'b1;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_en_nxt    = 1'b0;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (w_ack_seen || r_pend) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.In_ready  = (r_state == ST_IDLE);
  assign bus.Busy      = (r_state != ST_IDLE);
  assign bus.Async_bus = r_bus;
  assign bus.bus_EN    = r_en;

endmodule
`default_nettype wire

// File: tb/tb_data_sync_launch.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sync_launch
// Description : Directed self-checking bench for data_sync_launch. Three
//               instances: level mode HOLD_CYCLES=4, toggle mode, and level
//               mode HOLD_CYCLES=6 for the early-acknowledge case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sync_launch;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_fail;

  data_sync_launch_if #(.Width(8)) if_lvl ();
  data_sync_launch_if #(.Width(8)) if_tog ();
  data_sync_launch_if #(.Width(8)) if_early ();

  data_sync_launch #(.Width(8), .NUM_Stages(2), .S_TO_F(1), .HOLD_CYCLES(4)) u_lvl (
    .CLK(CLK), .Reset(Reset), .bus(if_lvl)
  );
  data_sync_launch #(.Width(8), .NUM_Stages(2), .S_TO_F(0), .HOLD_CYCLES(4)) u_tog (
    .CLK(CLK), .Reset(Reset), .bus(if_tog)
  );
  data_sync_launch #(.Width(8), .NUM_Stages(2), .S_TO_F(1), .HOLD_CYCLES(6)) u_early (
    .CLK(CLK), .Reset(Reset), .bus(if_early)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full level-mode transfer: accept at edge k, ack toggled after k+8.
  task automatic lvl_xfer(input logic [7:0] d, input string tg);
    if_lvl.In_data  = d;
    if_lvl.In_valid = 1'b1;
    tick();                                   // edge k
    check_eq({tg, "_bus_k"}, 32'(if_lvl.Async_bus), 32'(d));
    check_eq({tg, "_rdy_k"}, 32'(if_lvl.In_ready), 32'd0);
    check_eq({tg, "_en_k"},  32'(if_lvl.bus_EN), 32'd0);
    if_lvl.In_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("%s_en_k%0d", tg, i), 32'(if_lvl.bus_EN), 32'd1);
    end
    tick();                                   // k+5
    check_eq({tg, "_en_k5"}, 32'(if_lvl.bus_EN), 32'd0);
    repeat (3) tick();                        // k+8
    check_eq({tg, "_busy_k8"}, 32'(if_lvl.Busy), 32'd1);
    if_lvl.Ack_async = ~if_lvl.Ack_async;
    tick();
    tick();                                   // k+10
    check_eq({tg, "_rdy_k10"}, 32'(if_lvl.In_ready), 32'd0);
    tick();                                   // k+11
    check_eq({tg, "_rdy_k11"}, 32'(if_lvl.In_ready), 32'd1);
    check_eq({tg, "_bus_k11"}, 32'(if_lvl.Async_bus), 32'(d));
  endtask

  logic [7:0] tog_w [3];
  logic       tog_e [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tog_w[0] = 8'h11; tog_w[1] = 8'h22; tog_w[2] = 8'h33;
    tog_e[0] = 1'b1;  tog_e[1] = 1'b0;  tog_e[2] = 1'b1;

    Reset = 1'b1;
    if_lvl.In_data = '0;   if_lvl.In_valid = 1'b0;   if_lvl.Ack_async = 1'b0;
    if_tog.In_data = '0;   if_tog.In_valid = 1'b0;   if_tog.Ack_async = 1'b0;
    if_early.In_data = '0; if_early.In_valid = 1'b0; if_early.Ack_async = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_rdy",   32'(if_lvl.In_ready), 32'd1);
    check_eq("rst_busy",  32'(if_lvl.Busy), 32'd0);
    check_eq("rst_bus",   32'(if_lvl.Async_bus), 32'd0);
    check_eq("rst_en",    32'(if_lvl.bus_EN), 32'd0);
    check_eq("rst_tog_en", 32'(if_tog.bus_EN), 32'd0);
    check_eq("rst_early_rdy", 32'(if_early.In_ready), 32'd1);
    Reset = 1'b0;
    repeat (2) tick();

    // Level mode, 0xA5
    lvl_xfer(8'hA5, "lvl_a5");
    repeat (2) tick();

    // Reset asserted mid-HOLD
    if_lvl.In_data  = 8'h3C;
    if_lvl.In_valid = 1'b1;
    tick();                                   // accept
    if_lvl.In_valid = 1'b0;
    tick();
    tick();
    check_eq("midrst_en_before", 32'(if_lvl.bus_EN), 32'd1);
    #2;
    Reset = 1'b1;
    if_lvl.Ack_async = 1'b0;
    #1;
    check_eq("midrst_en",   32'(if_lvl.bus_EN), 32'd0);
    check_eq("midrst_bus",  32'(if_lvl.Async_bus), 32'd0);
    check_eq("midrst_rdy",  32'(if_lvl.In_ready), 32'd1);
    check_eq("midrst_busy", 32'(if_lvl.Busy), 32'd0);
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    lvl_xfer(8'h77, "lvl_77");

    // Toggle mode with back-pressure: In_valid stays high, junk data while busy
    for (int i = 0; i < 3; i++) begin
      if_tog.In_data  = tog_w[i];
      if_tog.In_valid = 1'b1;
      tick();                                 // edge k
      check_eq($sformatf("tog%0d_bus_k", i),  32'(if_tog.Async_bus), 32'(tog_w[i]));
      check_eq($sformatf("tog%0d_busy_k", i), 32'(if_tog.Busy), 32'd1);
      if_tog.In_data = 8'hE0 | 8'(i);
      tick();                                 // k+1
      check_eq($sformatf("tog%0d_en", i), 32'(if_tog.bus_EN), 32'(tog_e[i]));
      if_tog.Ack_async = ~if_tog.Ack_async;
      if_tog.In_data = 8'hF0 | 8'(i);
      tick();                                 // k+2
      check_eq($sformatf("tog%0d_bus_k2", i), 32'(if_tog.Async_bus), 32'(tog_w[i]));
      tick();                                 // k+3
      check_eq($sformatf("tog%0d_busy_k3", i), 32'(if_tog.Busy), 32'd1);
      check_eq($sformatf("tog%0d_en_k3", i), 32'(if_tog.bus_EN), 32'(tog_e[i]));
      tick();                                 // k+4
      check_eq($sformatf("tog%0d_rdy_k4", i), 32'(if_tog.In_ready), 32'd1);
      check_eq($sformatf("tog%0d_bus_k4", i), 32'(if_tog.Async_bus), 32'(tog_w[i]));
    end
    if_tog.In_valid = 1'b0;
    tick();

    // Early ack during HOLD, HOLD_CYCLES=6
    if_early.In_data  = 8'hC3;
    if_early.In_valid = 1'b1;
    tick();                                   // k
    check_eq("early_bus", 32'(if_early.Async_bus), 32'h0C3);
    if_early.In_valid = 1'b0;
    tick();                                   // k+1
    check_eq("early_en_k1", 32'(if_early.bus_EN), 32'd1);
    tick();                                   // k+2
    if_early.Ack_async = ~if_early.Ack_async;
    repeat (4) tick();                        // k+6
    check_eq("early_en_k6", 32'(if_early.bus_EN), 32'd1);
    check_eq("early_busy_k6", 32'(if_early.Busy), 32'd1);
    tick();                                   // k+7
    check_eq("early_en_k7", 32'(if_early.bus_EN), 32'd0);
    check_eq("early_busy_k7", 32'(if_early.Busy), 32'd1);
    tick();                                   // k+8
    check_eq("early_rdy_k8", 32'(if_early.In_ready), 32'd1);
    check_eq("early_bus_k8", 32'(if_early.Async_bus), 32'h0C3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sync_launch.md
# data_sync_launch

Source-domain launcher for the enable-based CDC data path. It accepts a word on a valid/ready handshake, drives it onto a quasi-static bus, and then signals the destination domain through a single enable line. In level mode the line is a pulse held for a programmed number of cycles. In toggle mode the line flips once per word. The block keeps the bus stable until the destination returns a toggle acknowledge, which it synchronizes into its own clock, so no word is overwritten before the far-end synchronizer has sampled it.

## Interface
- Width, 8: data bus width.
- NUM_Stages, 2: synchronizer flops on Ack_async; minimum 2.
- S_TO_F, 1: enable encoding; must match the destination synchronizer. 1 = level pulse of HOLD_CYCLES cycles; 0 = toggle per word.
- HOLD_CYCLES, 4: cycles bus_EN stays high in level mode; minimum 1; ignored when S_TO_F=0.

Ports:
- CLK  input  1  source-domain clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In_data  input  Width  word to transfer.
- In_valid  input  1  In_data valid.
- In_ready  output  1  block can accept a word (high only in IDLE).
- Async_bus  output  Width  registered data held toward destination domain.
- bus_EN  output  1  registered enable toward destination synchronizer.
- Ack_async  input  1  toggle acknowledge from destination domain (asynchronous).
- Busy  output  1  equals ~In_ready.

## Operation
- Reset values: state IDLE, Async_bus=0, bus_EN=0, hold counter=0, ack sync chain=0, ack_prev=0, ack_pending=0; therefore In_ready=1 and Busy=0 during and after reset.
- States: IDLE, SETUP, HOLD, WAIT_ACK.
- IDLE:
  - In_ready=1.
  - On In_valid&In_ready: Async_bus<=In_data, go to SETUP.
  - Otherwise Async_bus holds its value.
- SETUP (1 cycle): data has already been stable for one cycle. Update the enable:
  - S_TO_F=1: bus_EN<=1, counter<=HOLD_CYCLES-1, go to HOLD.
  - S_TO_F=0: bus_EN<=~bus_EN, go to WAIT_ACK.
- HOLD (S_TO_F=1 only): while counter!=0, decrement. At counter==0, bus_EN<=0 and go to WAIT_ACK.
- WAIT_ACK:
  - bus_EN holds (0 in level mode, toggled value in toggle mode).
  - Go to IDLE on the edge where ack_seen or ack_pending is true; clear ack_pending on that edge.
- Ack path:
  - Ack_async passes through NUM_Stages flops (ack_sync).
  - ack_prev<=ack_sync[last] every cycle.
  - ack_seen = ack_sync[last]^ack_prev, a 1-cycle pulse per ack toggle.
- An ack_seen during SETUP or HOLD sets ack_pending, so an early ack is never lost.
- An ack_seen in IDLE is ignored; it is a protocol violation by the far end.
- Async_bus changes only on an accept edge and is never modified between SETUP and the return to IDLE.
- In_valid while In_ready=0 is ignored. No buffering: the source must hold In_data and In_valid until accepted.
- Reset mid-transfer aborts immediately with all values as listed above. In toggle mode the destination must be reset together with this block so the two toggle parities stay aligned.
- Integration rule, level mode: HOLD_CYCLES × source period ≥ (NUM_Stages+1) destination periods + margin.

## Timing
- Accept at edge k: Async_bus valid after k; In_ready low from k.
- bus_EN changes at edge k+1.
- Level mode: bus_EN high for exactly HOLD_CYCLES cycles, edges k+1 through k+1+HOLD_CYCLES. Earliest return to IDLE is edge k+2+HOLD_CYCLES, if the ack was already pending.
- Ack latency: a toggle on Ack_async (meeting setup) produces ack_seen NUM_Stages cycles later. The state becomes IDLE on the following edge, and In_ready=1 in that cycle.
- Minimum spacing between accepts is therefore 2+NUM_Stages+1 cycles (toggle mode) plus far-end round trip.
- In_ready and Busy are decoded from state, with no extra register delay.

## Test plan
- Reset: assert Reset mid-HOLD with bus_EN=1 → bus_EN=0, Async_bus=0, In_ready=1 asynchronously; first word after release transfers normally.
- Level mode, HOLD_CYCLES=4, NUM_Stages=2: accept 0xA5 at edge k → Async_bus=0xA5 after k; bus_EN=1 for edges k+1..k+4, 0 at k+5; toggle Ack_async after k+8 → In_ready=1 three edges later.
- Toggle mode (S_TO_F=0): send 0x11, 0x22, 0x33 with acks → bus_EN sequence 1,0,1; Async_bus never changes while Busy=1.
- Early ack: toggle Ack_async during HOLD (HOLD_CYCLES=6) → ack_pending set; IDLE reached exactly one edge after HOLD ends, with no ack needed in WAIT_ACK.
- Back-pressure: hold In_valid=1 with changing In_data while Busy=1 → ignored; next word accepted on the first IDLE cycle.
- End-to-end: pair with the destination synchronizer at 3:1 and 1:3 clock ratios, 200 random words → every word delivered once, in order, uncorrupted.
